// File: rtl/microcode_sequencer.sv
// microcode_sequencer: control-unit sequencer producing the per-cycle control word for the CPU datapath.
// Runs two fetch steps, latches the opcode, then walks external microcode ROM steps until end-of-instruction.
module microcode_sequencer #(
    parameter int unsigned          CW_WIDTH    = 32,
    parameter logic [CW_WIDTH-1:0]  IDLE_WORD   = 32'h3BF83FCF,
    parameter logic [CW_WIDTH-1:0]  FETCH0_WORD = 32'h3BF83FCF,
    parameter logic [CW_WIDTH-1:0]  FETCH1_WORD = 32'h3BF83FCF,
    parameter int unsigned          STEP_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              main_bus,
    input  logic [3:0]              flags,
    input  logic                    halt_req,
    output logic [12+STEP_BITS-1:0] uc_addr,
    input  logic [CW_WIDTH-1:0]     uc_data,
    input  logic                    uc_last,
    output logic [CW_WIDTH-1:0]     control_word,
    output logic                    ctrlen,
    output logic [7:0]              opcode,
    output logic [STEP_BITS-1:0]    step,
    output logic                    halted,
    output logic                    fault
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_FETCH1 = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [STEP_BITS-1:0] STEP_ZERO = {STEP_BITS{1'b0}};
    localparam logic [STEP_BITS-1:0] STEP_MAX  = {STEP_BITS{1'b1}};
    localparam logic [STEP_BITS-1:0] STEP_ONE  = {{(STEP_BITS-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [STEP_BITS-1:0]   step_q, step_d;
    logic                   fault_q, fault_d;

    // State, opcode, step and sticky fault registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RESET;
            opcode_q <= 8'h00;
            step_q   <= STEP_ZERO;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            step_q   <= step_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state sequencing; uc_last outranks step overrun, halt_req is only looked at on uc_last.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        step_d   = step_q;
        fault_d  = fault_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH0;
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: begin
                opcode_d = main_bus;
                step_d   = STEP_ZERO;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                if (uc_last) begin
                    step_d  = STEP_ZERO;
                    state_d = halt_req ? ST_HALTED : ST_FETCH0;
                end else if (step_q == STEP_MAX) begin
                    step_d  = STEP_ZERO;
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    step_d  = step_q + STEP_ONE;
                    state_d = ST_EXEC;
                end
            end
            ST_HALTED: begin
                if (!fault_q && !halt_req) begin
                    state_d = ST_FETCH0;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d  = ST_RESET;
                opcode_d = 8'h00;
                step_d   = STEP_ZERO;
            end
        endcase
    end

    // Output decode; the ROM word passes straight through while executing.
    always_comb begin
        control_word = IDLE_WORD;
        ctrlen       = 1'b0;
        halted       = 1'b0;
        case (state_q)
            ST_RESET: begin
                control_word = IDLE_WORD;
                ctrlen       = 1'b0;
            end
            ST_FETCH0: begin
                control_word = FETCH0_WORD;
                ctrlen       = 1'b1;
            end
            ST_FETCH1: begin
                control_word = FETCH1_WORD;
                ctrlen       = 1'b1;
            end
            ST_EXEC: begin
                control_word = uc_data;
                ctrlen       = 1'b1;
            end
            ST_HALTED: begin
                control_word = IDLE_WORD;
                ctrlen       = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                control_word = IDLE_WORD;
                ctrlen       = 1'b0;
            end
        endcase
    end

    assign uc_addr = {opcode_q, flags, step_q};
    assign opcode  = opcode_q;
    assign step    = step_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomised scoreboard bench for microcode_sequencer against a cycle-level behavioural model.
module tb_microcode_sequencer;

    localparam logic [31:0] IDLE = 32'h3BF83FCF;
    localparam logic [31:0] F0W  = 32'hF0F00001;
    localparam logic [31:0] F1W  = 32'hF1F10002;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] cw;
        logic        en;
        logic        halted;
        logic        fault;
        logic [7:0]  op;
        logic [3:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, halt_req, uc_last, ctrlen, halted, fault;
    logic [7:0]  main_bus, opcode;
    logic [3:0]  flags, step;
    logic [15:0] uc_addr;
    logic [31:0] uc_data, control_word;

    int   len_tbl [256];
    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    // Model: phase 0 reset, 1 first fetch, 2 second fetch, 3 executing, 4 halted.
    int         m_ph = 0;
    logic [7:0] m_op = 8'h00;
    int         m_step = 0;
    bit         m_fault = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, a + 16'h1357};
    endfunction

    // Microcode ROM stub: word derived from address, end mark from per-opcode instruction length.
    always_comb begin
        uc_data = rom_word(uc_addr);
        uc_last = ((int'(uc_addr[3:0]) + 1) == len_tbl[uc_addr[15:8]]);
    end

    microcode_sequencer #(
        .CW_WIDTH(32), .IDLE_WORD(IDLE), .FETCH0_WORD(F0W), .FETCH1_WORD(F1W), .STEP_BITS(4)
    ) dut (
        .clk(clk), .rst(rst), .main_bus(main_bus), .flags(flags), .halt_req(halt_req),
        .uc_addr(uc_addr), .uc_data(uc_data), .uc_last(uc_last), .control_word(control_word),
        .ctrlen(ctrlen), .opcode(opcode), .step(step), .halted(halted), .fault(fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive inputs, push the expected outputs, advance the model.
    task automatic cycle(input bit rv, input logic [7:0] bus, input logic [3:0] fl, input bit hr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rv; main_bus = bus; flags = fl; halt_req = hr;
        if (!rv) begin
            m_ph = 0; m_op = 8'h00; m_step = 0; m_fault = 1'b0;
        end
        e.addr   = {m_op, fl, 4'(m_step)};
        e.op     = m_op;
        e.st     = 4'(m_step);
        e.fault  = m_fault;
        e.halted = (m_ph == 4);
        e.en     = (m_ph != 0);
        case (m_ph)
            1:       e.cw = F0W;
            2:       e.cw = F1W;
            3:       e.cw = rom_word(e.addr);
            default: e.cw = IDLE;
        endcase
        exp_q.push_back(e);
        if (rv) begin
            case (m_ph)
                0: m_ph = 1;
                1: m_ph = 2;
                2: begin m_op = bus; m_step = 0; m_ph = 3; end
                3: begin
                    if (m_step + 1 == len_tbl[m_op]) begin
                        m_step = 0;
                        m_ph = hr ? 4 : 1;
                    end else if (m_step == 15) begin
                        m_fault = 1'b1; m_step = 0; m_ph = 4;
                    end else begin
                        m_step = m_step + 1;
                    end
                end
                default: if (!m_fault && !hr) m_ph = 1;
            endcase
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=reached", name);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest prediction.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("control_word", control_word, e.cw);
            chk("ctrlen", {31'd0, ctrlen}, {31'd0, e.en});
            chk("halted", {31'd0, halted}, {31'd0, e.halted});
            chk("fault", {31'd0, fault}, {31'd0, e.fault});
            chk("opcode", {24'd0, opcode}, {24'd0, e.op});
            chk("step", {28'd0, step}, {28'd0, e.st});
            chk("uc_addr", {16'd0, uc_addr}, {16'd0, e.addr});
        end
    end

    initial begin
        int n;
        int fault_age;
        rst = 1'b0; main_bus = 8'h00; flags = 4'h0; halt_req = 1'b0;
        for (int i = 0; i < 256; i++) len_tbl[i] = $urandom_range(1, 4);
        len_tbl[8'h42] = 3;
        len_tbl[8'h33] = 3;
        len_tbl[8'h11] = 1;
        len_tbl[8'hFE] = 16;
        len_tbl[8'hFF] = 17;

        cycle(1'b0, 8'h00, 4'h0, 1'b0);
        cycle(1'b0, 8'h00, 4'h0, 1'b0);

        // Fetch/decode and multi-step with two flag patterns for the same opcode.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h42, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h42, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h11, 4'b1010, 1'b0);

        // Halt raised mid-instruction, honoured at its end, then resume.
        n = 0;
        while (!(m_ph == 3 && m_step == 1) && n < 20) begin
            cycle(1'b1, 8'h33, 4'h0, 1'b0);
            n++;
        end
        if (n >= 20) bound_fail("reach_halt_step");
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h33, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h33, 4'h0, 1'b0);

        // Asynchronous reset at exec step 3.
        n = 0;
        while (!(m_ph == 3 && m_step == 3) && n < 30) begin
            cycle(1'b1, 8'hFE, 4'h3, 1'b0);
            n++;
        end
        if (n >= 30) bound_fail("reach_step3");
        cycle(1'b0, 8'hFE, 4'h3, 1'b0);
        cycle(1'b1, 8'hFE, 4'h3, 1'b0);
        cycle(1'b1, 8'hFE, 4'h3, 1'b0);

        // Full 16-step instruction ending on the last step, then an overrun.
        for (int i = 0; i < 22; i++) cycle(1'b1, 8'hFE, 4'h5, 1'b0);
        n = 0;
        while (!m_fault && n < 60) begin
            cycle(1'b1, 8'hFF, 4'h0, 1'b0);
            n++;
        end
        if (n >= 60) bound_fail("reach_overrun");
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00, 4'h0, 1'b0);
        cycle(1'b0, 8'h00, 4'h0, 1'b0);

        // Randomised traffic with occasional resets.
        fault_age = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] bus;
            bit rv;
            bus = ($urandom_range(0, 9) == 0) ? 8'hFF :
                  ($urandom_range(0, 9) == 0) ? 8'hFE : 8'($urandom);
            fault_age = m_fault ? fault_age + 1 : 0;
            rv = ($urandom_range(0, 199) != 0) && (fault_age < 6);
            cycle(rv, bus, 4'($urandom), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) bound_fail("scoreboard_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
